// File: rtl/conv_window_stream_pkg.sv
// Shared types and elaboration-time helpers for the convolution window streamer.
// Holds the frame FSM encoding, the padded/output dimension formulas and the coordinate width.
package conv_pkg;

   localparam int COORD_W = 16;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      RUN   = 2'd1,
      FLUSH = 2'd2
   } conv_state_e;

   function automatic int padded_dim(input int img, input int pad);
      return img + 2 * pad;
   endfunction

   function automatic int out_dim(input int padded, input int k, input int stride);
      return (padded - k) / stride + 1;
   endfunction

endpackage

// File: rtl/conv_window_stream_if.sv
// Pixel-in and window-out handshake bundle of the window streamer.
// Both channels: a beat transfers on a rising edge where valid & ready; valid, once high, holds its payload until that transfer.
interface conv_window_stream_if #(
   parameter int DW = 8,
   parameter int WW = 72
);
   logic                          in_valid;
   logic                          in_ready;
   logic [DW-1:0]                 in_data;
   logic                          win_valid;
   logic                          win_ready;
   logic [WW-1:0]                 win_data;
   logic [conv_pkg::COORD_W-1:0]  win_row;
   logic [conv_pkg::COORD_W-1:0]  win_col;

   modport master (
      output in_valid, in_data, win_ready,
      input  in_ready, win_valid, win_data, win_row, win_col
   );

   modport slave (
      input  in_valid, in_data, win_ready,
      output in_ready, win_valid, win_data, win_row, win_col
   );
endinterface

// File: rtl/conv_window_stream_line_buffer.sv
// One image-row delay line: the output is the sample pushed DEPTH enables earlier.
// Storage is never cleared; shifting is frozen while reset is held.
module conv_line_buffer #(
   parameter int WIDTH = 8,
   parameter int DEPTH = 32
) (
   input  logic             clk_en,
   input  logic             rst_n,
   input  logic             en,
   input  logic [WIDTH-1:0] din,
   output logic [WIDTH-1:0] dout
);
   logic [WIDTH-1:0] mem [DEPTH];

   always_ff @(posedge clk_en) begin
      if (en && rst_n) begin
         mem[0] <= din;
         for (int i = 1; i < DEPTH; i++) begin
            mem[i] <= mem[i-1];
         end
      end
   end

   assign dout = mem[DEPTH-1];

endmodule

// File: rtl/conv_window_stream.sv
// Raster-order sliding-window generator with built-in zero padding and stride.
// A padded-coordinate scanner pushes one sample per step; line buffers supply the upper window rows.
module conv_window_stream
   import conv_pkg::*;
#(
   parameter int BITWIDTH = 8,
   parameter int CHANNELS = 1,
   parameter int IMG_W    = 32,
   parameter int IMG_H    = 32,
   parameter int K_W      = 3,
   parameter int K_H      = 3,
   parameter int STRIDE   = 1,
   parameter int PADDING  = 0
) (
   input  logic                 clk_en,
   input  logic                 rst_n,
   input  logic                 start,
   conv_window_stream_if.slave  bus,
   output logic                 busy,
   output logic                 frame_done,
   output conv_state_e          state_dbg
);
   localparam int DW = CHANNELS * BITWIDTH;
   localparam int WW = K_H * K_W * DW;
   localparam int PW = padded_dim(IMG_W, PADDING);
   localparam int PH = padded_dim(IMG_H, PADDING);
   localparam logic [COORD_W-1:0] S_LAST = COORD_W'(STRIDE - 1);
   localparam logic [COORD_W-1:0] ONE    = COORD_W'(1);

   conv_state_e        state;
   logic [COORD_W-1:0] px, py;
   logic [COORD_W-1:0] c_ph, r_ph;
   logic [COORD_W-1:0] out_col, out_row;
   int                 px_i, py_i;
   logic               pad_coord, can_push, push;
   logic               row_ok, col_ok, emit;

   logic [DW-1:0]      col_in [K_H];
   logic [DW-1:0]      win_q  [K_H][K_W];
   logic [DW-1:0]      win_nx [K_H][K_W];
   logic [WW-1:0]      win_flat;

   assign px_i = int'(px);
   assign py_i = int'(py);

   assign pad_coord = (py_i < PADDING) || (py_i >= PADDING + IMG_H) ||
                      (px_i < PADDING) || (px_i >= PADDING + IMG_W);

   // A held, unaccepted window blocks the scanner so its payload stays stable.
   assign can_push    = (state == RUN) && (!bus.win_valid || bus.win_ready);
   assign push        = can_push && (pad_coord || bus.in_valid);
   assign bus.in_ready = can_push && !pad_coord;

   // Stride phases count from the first column/row where a full window exists.
   assign row_ok = (py_i >= K_H - 1) && (r_ph == '0);
   assign col_ok = (px_i >= K_W - 1) && (c_ph == '0);
   assign emit   = push && row_ok && col_ok;

   assign col_in[K_H-1] = pad_coord ? '0 : bus.in_data;

   for (genvar j = 0; j < K_H - 1; j++) begin : g_lb
      conv_line_buffer #(
         .WIDTH (DW),
         .DEPTH (PW)
      ) u_lb (
         .clk_en (clk_en),
         .rst_n  (rst_n),
         .en     (push),
         .din    (col_in[K_H-1-j]),
         .dout   (col_in[K_H-2-j])
      );
   end

   always_comb begin
      win_nx = win_q;
      for (int r = 0; r < K_H; r++) begin
         for (int c = 0; c < K_W - 1; c++) begin
            win_nx[r][c] = win_q[r][c+1];
         end
         win_nx[r][K_W-1] = col_in[r];
      end
   end

   always_comb begin
      win_flat = '0;
      for (int r = 0; r < K_H; r++) begin
         for (int c = 0; c < K_W; c++) begin
            win_flat[(r*K_W + c)*DW +: DW] = win_nx[r][c];
         end
      end
   end

   always_ff @(posedge clk_en) begin
      if (push) begin
         win_q <= win_nx;
      end
   end

   always_ff @(posedge clk_en) begin
      if (!rst_n) begin
         state         <= IDLE;
         px            <= '0;
         py            <= '0;
         c_ph          <= '0;
         r_ph          <= '0;
         out_col       <= '0;
         out_row       <= '0;
         bus.win_valid <= 1'b0;
         bus.win_data  <= '0;
         bus.win_row   <= '0;
         bus.win_col   <= '0;
         busy          <= 1'b0;
         frame_done    <= 1'b0;
      end else begin
         frame_done <= 1'b0;
         if (bus.win_valid && bus.win_ready) begin
            bus.win_valid <= 1'b0;
         end
         unique case (state)
            IDLE: begin
               busy <= 1'b0;
               if (start) begin
                  state   <= RUN;
                  busy    <= 1'b1;
                  px      <= '0;
                  py      <= '0;
                  c_ph    <= '0;
                  r_ph    <= '0;
                  out_col <= '0;
                  out_row <= '0;
               end
            end
            RUN: begin
               if (push) begin
                  // An emit here overrides the accept-clear above, so back-to-back windows keep valid high.
                  if (emit) begin
                     bus.win_valid <= 1'b1;
                     bus.win_data  <= win_flat;
                     bus.win_row   <= out_row;
                     bus.win_col   <= out_col;
                     out_col       <= out_col + ONE;
                  end
                  if (px_i == PW - 1) begin
                     px      <= '0;
                     c_ph    <= '0;
                     out_col <= '0;
                     if (py_i >= K_H - 1) begin
                        r_ph <= (r_ph == S_LAST) ? '0 : r_ph + ONE;
                     end
                     if (row_ok) begin
                        out_row <= out_row + ONE;
                     end
                     if (py_i == PH - 1) begin
                        state <= FLUSH;
                     end else begin
                        py <= py + ONE;
                     end
                  end else begin
                     px <= px + ONE;
                     if (px_i >= K_W - 1) begin
                        c_ph <= (c_ph == S_LAST) ? '0 : c_ph + ONE;
                     end
                  end
               end
            end
            FLUSH: begin
               if (!bus.win_valid) begin
                  state      <= IDLE;
                  frame_done <= 1'b1;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

   assign state_dbg = state;

endmodule
